iq_upconverter: RTL and testbench

//  Transmit-side counterpart of the IQ demodulator. Buffers baseband I/Q sample pairs

---
 rtl/iq_upconverter.sv | 150 +++++++++++++++
 tb/tb_iq_upconverter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_upconverter.sv
// Baseband I/Q upconverter: FIFO-buffered sample pairs held for HOLD clocks and
// mixed with an external NCO as out = I*cos - Q*sin, rounded and saturated.
module iq_upconverter #(
   parameter int N     = 14,
   parameter int HOLD  = 50,
   parameter int DEPTH = 4
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      enable,
   input  logic signed [N-1:0]       I_in,
   input  logic signed [N-1:0]       Q_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [N-1:0]       nco_cos,
   input  logic signed [N-1:0]       nco_sin,
   input  logic                      nco_valid,
   output logic signed [N-1:0]       out,
   output logic                      out_valid,
   output logic                      underrun,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [1:0]                dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(HOLD);
   localparam int SW = 2 * N + 1;
   localparam logic signed [SW-1:0] HALF = {{(N + 2){1'b0}}, 1'b1, {(N - 2){1'b0}}};
   localparam logic signed [SW-1:0] MAXV = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

   // Debug encoding on dbg_state: IDLE=0, PRIME=1, RUN=2.
   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
   state_t state, state_next;

   logic signed [N-1:0]   mem_i [DEPTH];
   logic signed [N-1:0]   mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         cnt;
   logic signed [N-1:0]   hold_i, hold_q;
   logic                  push, pop, wrap, starve, flush, advance;
   logic signed [2*N-1:0] p_i, p_q;
   logic                  v1;
   logic signed [SW-1:0]  diff, rnd, shifted;
   logic signed [N-1:0]   sat;

   // Handshake: a pair transfers on every clock where in_valid and in_ready are both
   // high; in_ready depends only on the registered level, never on a same-cycle pop.
   assign in_ready  = (fifo_level != LW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign wrap      = (state == RUN) && (cnt == CW'(HOLD - 1));
   assign flush     = (state_next == IDLE);
   assign advance   = nco_valid && (state == RUN);
   assign dbg_state = state;

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      starve     = 1'b0;
      case (state)
         IDLE:  if (enable) state_next = PRIME;
         PRIME: begin
            if (!enable) state_next = IDLE;
            else if (fifo_level >= LW'(2)) begin
               state_next = RUN;
               pop        = 1'b1;
            end
         end
         RUN: begin
            if (!enable) state_next = IDLE;
            else if (wrap) begin
               if (fifo_level != '0) pop = 1'b1;
               else starve = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_i[wr_ptr] <= I_in;
         mem_q[wr_ptr] <= Q_in;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cnt        <= '0;
         hold_i     <= '0;
         hold_q     <= '0;
         underrun   <= 1'b0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
         if (state == RUN && state_next == RUN) cnt <= wrap ? '0 : cnt + 1'b1;
         else                                   cnt <= '0;
         // Outside RUN, or when the FIFO runs dry at a boundary, the carrier is muted.
         if (pop) begin
            hold_i <= mem_i[rd_ptr];
            hold_q <= mem_q[rd_ptr];
         end else if (starve || state_next != RUN) begin
            hold_i <= '0;
            hold_q <= '0;
         end
         if (starve) underrun <= 1'b1;
      end
   end

   assign diff    = {p_i[2*N-1], p_i} - {p_q[2*N-1], p_q};
   assign rnd     = diff + HALF;
   assign shifted = rnd >>> (N - 1);

   always_comb begin
      sat = shifted[N-1:0];
      if (shifted > MAXV)      sat = MAXV[N-1:0];
      else if (shifted < MINV) sat = MINV[N-1:0];
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         p_i       <= '0;
         p_q       <= '0;
         v1        <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         v1        <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         v1 <= advance;
         if (advance) begin
            p_i <= $signed({{N{hold_i[N-1]}}, hold_i}) * $signed({{N{nco_cos[N-1]}}, nco_cos});
            p_q <= $signed({{N{hold_q[N-1]}}, hold_q}) * $signed({{N{nco_sin[N-1]}}, nco_sin});
         end
         out_valid <= v1;
         if (v1) out <= sat;
      end
   end

endmodule

// File: tb/tb_iq_upconverter.sv
// Directed-plus-random bench for iq_upconverter: each run's output stream is compared
// with a stream built from the pushed pairs, HOLD, and exact integer mixing arithmetic.
module tb_iq_upconverter;

   localparam int N     = 14;
   localparam int HOLD  = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam longint MAXO = (longint'(1) << (N - 1)) - 1;
   localparam longint MINO = -(longint'(1) << (N - 1));

   logic                 CLK = 1'b0;
   logic                 reset, enable, in_valid, nco_valid;
   logic                 in_ready, out_valid, underrun;
   logic signed [N-1:0]  I_in, Q_in, nco_cos, nco_sin, out;
   logic [N-1:0]         out_u;
   logic [LW-1:0]        fifo_level;
   logic [1:0]           dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int pair_i[$];
   int pair_q[$];
   int cur_cos, cur_sin;

   assign out_u = out;

   iq_upconverter #(.N(N), .HOLD(HOLD), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .reset(reset), .enable(enable),
      .I_in(I_in), .Q_in(Q_in), .in_valid(in_valid), .in_ready(in_ready),
      .nco_cos(nco_cos), .nco_sin(nco_sin), .nco_valid(nco_valid),
      .out(out), .out_valid(out_valid), .underrun(underrun),
      .fifo_level(fifo_level), .dbg_state(dbg_state)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
      $fatal(1, "watchdog");
   end

   // Reference: out = floor((I*cos - Q*sin + 2^(N-2)) / 2^(N-1)), clamped to N bits.
   function automatic logic [N-1:0] mix(input int i, input int q, input int c, input int s);
      longint x, r, d;
      d = longint'(1) << (N - 1);
      x = longint'(i) * longint'(c) - longint'(q) * longint'(s) + (longint'(1) << (N - 2));
      if (x >= 0) r = x / d;
      else        r = -((-x + d - 1) / d);
      if (r > MAXO) r = MAXO;
      if (r < MINO) r = MINO;
      mix = r[N-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Driver tasks
   task automatic apply_reset();
      reset     = 1'b1;
      enable    = 1'b0;
      in_valid  = 1'b0;
      I_in      = '0;
      Q_in      = '0;
      nco_cos   = '0;
      nco_sin   = '0;
      nco_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1 reset = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic add_pair(input int i, input int q);
      pair_i.push_back(i);
      pair_q.push_back(q);
   endtask

   task automatic clear_pairs();
      pair_i.delete();
      pair_q.delete();
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
   endfunction

   function automatic int rnd_nco();
      return int'($urandom_range(0, (1 << N) - 2)) - ((1 << (N - 1)) - 1);
   endfunction

   // n_pre pairs are offered back-to-back with enable low (extra ones must be dropped),
   // then enable rises and n_live more pairs are offered whenever in_ready allows.
   // run_start is the cycle (counted from enable rising) of the first RUN clock.
   task automatic run_case(input string tag, input int n_pre, input int n_live, input int run_start);
      logic [N-1:0] exp_q[$];
      logic [N-1:0] obs_q[$];
      int stored, total, idx, fv, ur, ncyc, nchk;
      stored = (n_pre < DEPTH) ? n_pre : DEPTH;
      total  = stored + n_live;
      fv     = -1;
      ur     = -1;
      apply_reset();
      nco_cos   = N'(cur_cos);
      nco_sin   = N'(cur_sin);
      nco_valid = 1'b1;
      for (int k = 0; k < n_pre; k++) begin
         in_valid = 1'b1;
         I_in     = N'(pair_i[k]);
         Q_in     = N'(pair_q[k]);
         tick();
      end
      in_valid = 1'b0;
      check({tag, "_prefill_level"}, 32'(fifo_level), 32'(stored));
      check({tag, "_prefill_ready"}, 32'(in_ready), 32'(stored != DEPTH));

      enable = 1'b1;
      idx    = n_pre;
      ncyc   = run_start + HOLD * total + 8;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         if (out_valid) begin
            obs_q.push_back(out_u);
            if (fv < 0) fv = cyc;
         end
         if (underrun && ur < 0) ur = cyc;
         if (idx < n_pre + n_live && in_ready) begin
            in_valid = 1'b1;
            I_in     = N'(pair_i[idx]);
            Q_in     = N'(pair_q[idx]);
            idx++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;

      for (int k = 0; k < stored; k++)
         for (int h = 0; h < HOLD; h++) exp_q.push_back(mix(pair_i[k], pair_q[k], cur_cos, cur_sin));
      for (int k = n_pre; k < n_pre + n_live; k++)
         for (int h = 0; h < HOLD; h++) exp_q.push_back(mix(pair_i[k], pair_q[k], cur_cos, cur_sin));
      while (exp_q.size() < ncyc - (run_start + 2)) exp_q.push_back('0);

      check({tag, "_first_valid_cycle"}, 32'(fv), 32'(run_start + 2));
      check({tag, "_underrun_cycle"}, 32'(ur), 32'(run_start + HOLD * total));
      check({tag, "_underrun_sticky"}, 32'(underrun), 32'd1);
      check({tag, "_n_outputs"}, 32'(obs_q.size()), 32'(exp_q.size()));
      nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < nchk; k++)
         check($sformatf("%s_out%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
   endtask

   // Scenario sequence and final report
   initial begin
      int n, first;
      logic [N-1:0] first_v;

      apply_reset();
      check("reset_out", 32'(out_u), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_underrun", 32'(underrun), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_fifo_level", 32'(fifo_level), 32'd0);
      check("reset_state_idle", 32'(dbg_state), 32'd0);

      cur_cos = 8191; cur_sin = 0;
      clear_pairs();
      add_pair(4096, 0); add_pair(4096, 0);
      run_case("t1_gain", 0, 2, 3);

      cur_cos = 8191; cur_sin = 8191;
      clear_pairs();
      add_pair(8191, -8192); add_pair(-8192, 8191);
      run_case("t2_sat", 0, 2, 3);

      cur_cos = 8191; cur_sin = 0;
      clear_pairs();
      add_pair(100, 0); add_pair(200, 0); add_pair(300, 0);
      run_case("t3_hold", 0, 3, 3);

      for (int r = 0; r < 3; r++) begin
         cur_cos = rnd_nco(); cur_sin = rnd_nco();
         clear_pairs();
         n = $urandom_range(2, 6);
         for (int k = 0; k < n; k++) add_pair(rnd_sample(), rnd_sample());
         run_case($sformatf("rnd%0d", r), 0, n, 3);
      end

      cur_cos = rnd_nco(); cur_sin = rnd_nco();
      clear_pairs();
      for (int k = 0; k < 5; k++) add_pair(rnd_sample(), rnd_sample());
      run_case("t5_full", 5, 0, 2);

      // enable drops on the wrap cycle: IDLE wins, nothing is popped, pipeline flushes
      cur_cos = rnd_nco(); cur_sin = rnd_nco();
      clear_pairs();
      for (int k = 0; k < 4; k++) add_pair(rnd_sample(), rnd_sample());
      apply_reset();
      nco_cos = N'(cur_cos); nco_sin = N'(cur_sin); nco_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; I_in = N'(pair_i[k]); Q_in = N'(pair_q[k]);
         tick();
      end
      in_valid = 1'b0;
      enable = 1'b1;
      repeat (5) tick();
      check("t7_level_before_drop", 32'(fifo_level), 32'd3);
      check("t7_out_before_drop", 32'(out_u), 32'(mix(pair_i[0], pair_q[0], cur_cos, cur_sin)));
      enable = 1'b0;
      tick();
      check("t7_level_no_pop", 32'(fifo_level), 32'd3);
      check("t7_flush_valid", 32'(out_valid), 32'd0);
      check("t7_flush_out", 32'(out_u), 32'd0);
      enable  = 1'b1;
      first   = -1;
      first_v = '0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (out_valid && first < 0) begin
            first   = cyc;
            first_v = out_u;
         end
         tick();
      end
      check("t7_resume_latency", 32'(first), 32'd4);
      check("t7_resume_pair1", 32'(first_v), 32'(mix(pair_i[1], pair_q[1], cur_cos, cur_sin)));

      // asynchronous reset in the middle of RUN with underrun set and data buffered
      cur_cos = 8191; cur_sin = 0;
      clear_pairs();
      add_pair(3000, 0); add_pair(3000, 0);
      run_case("t6_pre", 0, 2, 3);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; I_in = N'(2500); Q_in = '0;
         tick();
      end
      in_valid = 1'b0;
      repeat (5) tick();
      check("t6_out_before_reset", 32'(out_u), 32'(mix(2500, 0, cur_cos, cur_sin)));
      check("t6_underrun_before_reset", 32'(underrun), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_out", 32'(out_u), 32'd0);
      check("t6_async_out_valid", 32'(out_valid), 32'd0);
      check("t6_async_level", 32'(fifo_level), 32'd0);
      check("t6_async_underrun", 32'(underrun), 32'd0);
      check("t6_async_in_ready", 32'(in_ready), 32'd1);
      tick();
      reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
